// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: select -> quantity -> confirm -> pay -> vend -> change,
// with cancel/timeout refund. All outputs are registered.
module vend_txn_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_QTY        = 9
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  output logic [7:0] display_value_o,
  output logic       vend_o,
  output logic [2:0] product_id_o,
  output logic [3:0] qty_o,
  output logic       change_valid_o,
  output logic [7:0] change_amount_o,
  output logic       refund_o,
  output logic       busy_o,
  output logic [2:0] state_dbg_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SELECT = 3'd1, S_QTY = 3'd2, S_CONFIRM = 3'd3,
    S_PAY = 3'd4, S_VEND = 3'd5, S_CHANGE = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    prod_q, prod_d;
  logic [3:0]    qty_q, qty_d;
  logic [7:0]    price_q, price_d, total_q, total_d, paid_q, paid_d;
  logic [7:0]    change_q, change_d, disp_q, disp_d, ca_q, ca_d;
  logic          vend_q, vend_d, cv_q, cv_d, refund_q, refund_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       kv, active, go_vend, timeout, cancel;
  logic [7:0] coin, lut_price;
  logic [8:0] paid_sum;

  always_comb begin
    lut_price = 8'd0;
    case (key_code_i)
      4'd1: lut_price = 8'd9;
      4'd2: lut_price = 8'd12;
      4'd3: lut_price = 8'd10;
      4'd4: lut_price = 8'd8;
      4'd5: lut_price = 8'd2;
      default: lut_price = 8'd0;
    endcase
    coin = 8'd0;
    case (key_code_i)
      4'd4: coin = 8'd2;
      4'd5: coin = 8'd5;
      4'd6: coin = 8'd10;
      default: coin = 8'd0;
    endcase
  end

  assign kv       = key_valid_i;
  assign active   = (state_q == S_SELECT) || (state_q == S_QTY) ||
                    (state_q == S_CONFIRM) || (state_q == S_PAY);
  assign go_vend  = (state_q == S_PAY) && (paid_q >= total_q);
  // A key arriving on the expiry cycle wins: it restarts the timer instead.
  assign timeout  = !kv && active && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign cancel   = !go_vend && active && ((kv && key_code_i == 4'hC) || timeout);
  assign paid_sum = {1'b0, paid_q} + {1'b0, coin};

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    qty_d    = qty_q;
    price_d  = price_q;
    total_d  = total_q;
    paid_d   = paid_q;
    change_d = change_q;
    disp_d   = disp_q;
    vend_d   = 1'b0;
    cv_d     = 1'b0;
    ca_d     = 8'd0;
    refund_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        disp_d = 8'd0;
        if (kv && key_code_i == 4'hF) state_d = S_SELECT;
      end
      S_SELECT: if (kv && key_code_i >= 4'd1 && key_code_i <= 4'd5) begin
        prod_d  = key_code_i[2:0];
        price_d = lut_price;
        disp_d  = lut_price;
        qty_d   = 4'd0;
        state_d = S_QTY;
      end
      S_QTY: if (kv && key_code_i <= 4'd9) begin
        qty_d  = key_code_i;
        disp_d = {4'd0, key_code_i};
      end else if (kv && key_code_i == 4'hE) begin
        if (qty_q >= 4'd1 && qty_q <= 4'(MAX_QTY)) begin
          total_d = price_q * {4'd0, qty_q};
          disp_d  = price_q * {4'd0, qty_q};
          state_d = S_CONFIRM;
        end else begin
          qty_d = 4'd0;
        end
      end
      S_CONFIRM: if (kv && key_code_i == 4'hF) begin
        paid_d  = 8'd0;
        disp_d  = 8'd0;
        state_d = S_PAY;
      end
      S_PAY: if (go_vend) begin
        vend_d   = 1'b1;
        change_d = paid_q - total_q;
        state_d  = S_VEND;
      end else if (kv && coin != 8'd0) begin
        paid_d = paid_sum[8] ? 8'hFF : paid_sum[7:0];
        disp_d = paid_sum[8] ? 8'hFF : paid_sum[7:0];
      end
      S_VEND: begin
        cv_d    = 1'b1;
        ca_d    = change_q;
        disp_d  = change_q;
        state_d = S_CHANGE;
      end
      S_CHANGE: begin
        prod_d  = 3'd0;
        qty_d   = 4'd0;
        price_d = 8'd0;
        total_d = 8'd0;
        paid_d  = 8'd0;
        disp_d  = 8'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cancel) begin
      if (paid_q != 8'd0) begin
        cv_d     = 1'b1;
        refund_d = 1'b1;
        ca_d     = paid_q;
      end
      prod_d  = 3'd0;
      qty_d   = 4'd0;
      price_d = 8'd0;
      total_d = 8'd0;
      paid_d  = 8'd0;
      disp_d  = 8'd0;
      state_d = S_IDLE;
    end

    timer_d = (kv || state_d != state_q || !active) ? '0 : timer_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      prod_q   <= '0;
      qty_q    <= '0;
      price_q  <= '0;
      total_q  <= '0;
      paid_q   <= '0;
      change_q <= '0;
      disp_q   <= '0;
      vend_q   <= 1'b0;
      cv_q     <= 1'b0;
      ca_q     <= '0;
      refund_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      qty_q    <= qty_d;
      price_q  <= price_d;
      total_q  <= total_d;
      paid_q   <= paid_d;
      change_q <= change_d;
      disp_q   <= disp_d;
      vend_q   <= vend_d;
      cv_q     <= cv_d;
      ca_q     <= ca_d;
      refund_q <= refund_d;
      timer_q  <= timer_d;
    end
  end

  assign display_value_o = disp_q;
  assign vend_o          = vend_q;
  assign product_id_o    = prod_q;
  assign qty_o           = qty_q;
  assign change_valid_o  = cv_q;
  assign change_amount_o = ca_q;
  assign refund_o        = refund_q;
  assign busy_o          = (state_q != S_IDLE);
  assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed bench for vend_txn_controller: happy path, exact pay, cancel refund,
// timeout, bad quantity and asynchronous reset mid-transaction.
module tb_vend_txn_controller;
  logic       clk = 1'b0;
  logic       reset_ni;
  logic       key_valid_i;
  logic [3:0] key_code_i;
  logic [7:0] display_value_o, change_amount_o;
  logic       vend_o, change_valid_o, refund_o, busy_o;
  logic [2:0] product_id_o, state_dbg_o;
  logic [3:0] qty_o;

  int vectors = 0;
  int fails   = 0;
  int vend_cnt = 0;
  int cv_cnt   = 0;
  int vsnap, csnap;

  vend_txn_controller #(.TIMEOUT_CYCLES(1000), .MAX_QTY(9)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .key_valid_i(key_valid_i), .key_code_i(key_code_i),
    .display_value_o(display_value_o), .vend_o(vend_o), .product_id_o(product_id_o),
    .qty_o(qty_o), .change_valid_o(change_valid_o), .change_amount_o(change_amount_o),
    .refund_o(refund_o), .busy_o(busy_o), .state_dbg_o(state_dbg_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vend_o === 1'b1) vend_cnt++;
    if (change_valid_o === 1'b1) cv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid_i = 1'b1;
    key_code_i  = code;
    @(negedge clk);
    key_valid_i = 1'b0;
  endtask

  initial begin
    reset_ni    = 1'b0;
    key_valid_i = 1'b0;
    key_code_i  = 4'd0;
    #1;
    chk("rst_state", 32'(state_dbg_o), 0);
    chk("rst_disp",  32'(display_value_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_cv",    32'(change_valid_o), 0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;

    // Undefined key in IDLE is ignored
    press(4'd5);
    chk("idle_ignore", 32'(state_dbg_o), 0);

    // Happy path: product 2 (price 12) x3 = 36; pay 10+10+10+5+10 = 45
    press(4'hF); chk("hp_select", 32'(state_dbg_o), 1);
    press(4'd2); chk("hp_prod", 32'(product_id_o), 2);
    chk("hp_price_disp", 32'(display_value_o), 12);
    press(4'd3); chk("hp_qty", 32'(qty_o), 3);
    press(4'hE); chk("hp_confirm", 32'(state_dbg_o), 3);
    chk("hp_total", 32'(display_value_o), 36);
    press(4'd6); chk("hp_coin_in_confirm", 32'(state_dbg_o), 3);
    press(4'hF); chk("hp_pay", 32'(state_dbg_o), 4);
    chk("hp_paid0", 32'(display_value_o), 0);
    press(4'd6); press(4'd6); press(4'd6); press(4'd5);
    chk("hp_paid35", 32'(display_value_o), 35);
    chk("hp_still_pay", 32'(state_dbg_o), 4);
    vsnap = vend_cnt;
    press(4'd6);
    chk("hp_paid45", 32'(display_value_o), 45);
    @(negedge clk);
    chk("hp_vend_state", 32'(state_dbg_o), 5);
    chk("hp_vend", 32'(vend_o), 1);
    @(negedge clk);
    chk("hp_change_state", 32'(state_dbg_o), 6);
    chk("hp_cv", 32'(change_valid_o), 1);
    chk("hp_change", 32'(change_amount_o), 9);
    chk("hp_refund", 32'(refund_o), 0);
    chk("hp_disp_change", 32'(display_value_o), 9);
    @(negedge clk);
    chk("hp_idle", 32'(state_dbg_o), 0);
    chk("hp_busy", 32'(busy_o), 0);
    chk("hp_prod_clr", 32'(product_id_o), 0);
    chk("hp_vend_once", 32'(vend_cnt - vsnap), 1);

    // Exact pay: product 5 (price 2) x1, pay 2
    press(4'hF); press(4'd5); press(4'd1); press(4'hE);
    chk("ex_total", 32'(display_value_o), 2);
    press(4'hF); press(4'd4);
    @(negedge clk);
    chk("ex_vend", 32'(vend_o), 1);
    @(negedge clk);
    chk("ex_cv", 32'(change_valid_o), 1);
    chk("ex_change0", 32'(change_amount_o), 0);
    @(negedge clk);
    chk("ex_idle", 32'(state_dbg_o), 0);

    // Cancel in PAY with 10 paid -> refund
    press(4'hF); press(4'd1); press(4'd2); press(4'hE);
    chk("cn_total", 32'(display_value_o), 18);
    press(4'hF); press(4'd6);
    vsnap = vend_cnt;
    press(4'hC);
    chk("cn_idle", 32'(state_dbg_o), 0);
    chk("cn_cv", 32'(change_valid_o), 1);
    chk("cn_refund", 32'(refund_o), 1);
    chk("cn_amount", 32'(change_amount_o), 10);
    @(negedge clk);
    chk("cn_cv_pulse", 32'(change_valid_o), 0);
    chk("cn_no_vend", 32'(vend_cnt - vsnap), 0);

    // Timeout in QTY: 1000 idle cycles cancel, no refund (paid 0)
    press(4'hF); press(4'd3);
    csnap = cv_cnt;
    repeat (995) @(negedge clk);
    chk("to_before", 32'(busy_o), 1);
    repeat (7) @(negedge clk);
    chk("to_busy", 32'(busy_o), 0);
    chk("to_state", 32'(state_dbg_o), 0);
    chk("to_prod", 32'(product_id_o), 0);
    chk("to_no_cv", 32'(cv_cnt - csnap), 0);

    // Bad quantity then valid quantity, then cancel with nothing paid
    press(4'hF); press(4'd3);
    press(4'd0); press(4'hE);
    chk("bq_stay", 32'(state_dbg_o), 2);
    chk("bq_qty0", 32'(qty_o), 0);
    press(4'd7); press(4'd4);
    chk("bq_overwrite", 32'(qty_o), 4);
    press(4'hE);
    chk("bq_confirm", 32'(state_dbg_o), 3);
    chk("bq_total", 32'(display_value_o), 40);
    csnap = cv_cnt;
    press(4'hC);
    chk("bq_cancel", 32'(state_dbg_o), 0);
    chk("bq_no_refund", 32'(cv_cnt - csnap), 0);

    // Async reset in PAY with paid=7 (total 9)
    press(4'hF); press(4'd1); press(4'd1); press(4'hE); press(4'hF);
    press(4'd5); press(4'd4);
    chk("ar_paid7", 32'(display_value_o), 7);
    chk("ar_pay", 32'(state_dbg_o), 4);
    vsnap = vend_cnt;
    csnap = cv_cnt;
    @(negedge clk);
    #2 reset_ni = 1'b0;
    #1;
    chk("ar_state", 32'(state_dbg_o), 0);
    chk("ar_disp", 32'(display_value_o), 0);
    chk("ar_prod", 32'(product_id_o), 0);
    chk("ar_qty", 32'(qty_o), 0);
    chk("ar_busy", 32'(busy_o), 0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    repeat (5) @(negedge clk);
    chk("ar_no_vend", 32'(vend_cnt - vsnap), 0);
    chk("ar_no_refund", 32'(cv_cnt - csnap), 0);
    chk("ar_idle", 32'(state_dbg_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
